// File: rtl/data_split_if.sv
// data_split_if: producer/consumer bundle for the data_split nibble/byte unpacker.
//   start         : block enable
//   data_in       : byte to split, qualified by data_in_valid, accepted with data_in_ready
//   rd_en         : consumer requests one unit this cycle
//   byte_mode     : request width, 1 = byte (two nibbles), 0 = single nibble
//   data_o        : registered output unit, nibble appears as {4'h0, nibble}
//   data_en       : registered qualifier for data_o
//   underrun      : registered unavailable-request pulse (only with DATA_SPLIT_UNDERRUN_EN)
// master drives the requests, slave is the unpacker.
interface data_split_if;
  logic       start;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       rd_en;
  logic       byte_mode;
  logic [7:0] data_o;
  logic       data_en;
`ifdef DATA_SPLIT_UNDERRUN_EN
  logic       underrun;

  modport master (
    output start, data_in, data_in_valid, rd_en, byte_mode,
    input  data_in_ready, data_o, data_en, underrun
  );

  modport slave (
    input  start, data_in, data_in_valid, rd_en, byte_mode,
    output data_in_ready, data_o, data_en, underrun
  );
`else
  modport master (
    output start, data_in, data_in_valid, rd_en, byte_mode,
    input  data_in_ready, data_o, data_en
  );

  modport slave (
    input  start, data_in, data_in_valid, rd_en, byte_mode,
    output data_in_ready, data_o, data_en
  );
`endif
endinterface

// File: rtl/data_split.sv
// data_split: nibble/byte unpacker. Bytes are pushed MSB nibble first into a
// nibble-granular circular buffer; the consumer drains one byte or one nibble
// per cycle, so re-packing the output stream reproduces the input bytes.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : data_split_if.slave (start, data_in/valid/ready, rd_en, byte_mode,
//             data_o, data_en, optional underrun)
// Optional feature: define DATA_SPLIT_UNDERRUN_EN to add the underrun pulse.
// DEPTH is the buffer capacity in nibbles (even, >= 4).
module data_split #(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  data_split_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
`ifdef DATA_SPLIT_UNDERRUN_EN
  logic             un_q, un_d;
`endif

  logic             push_c;
  logic             pop_byte_c;
  logic             pop_nib_c;
  logic [PTR_W-1:0] rd_next_c;
  logic [PTR_W-1:0] wr_next_c;

  // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Ready ignores the same-cycle pop so the accept path stays shallow.
  assign bus.data_in_ready = reset_n & bus.start & (count_q <= CNT_W'(DEPTH - 2));
  assign push_c            = bus.data_in_valid & bus.data_in_ready;
  assign rd_next_c         = ptr_add(rd_ptr_q, 1);
  assign wr_next_c         = ptr_add(wr_ptr_q, 1);

  // Pop decisions use the pre-push count; a byte never pops a lone nibble.
  assign pop_byte_c = bus.start & bus.rd_en &  bus.byte_mode & (count_q >= CNT_W'(2));
  assign pop_nib_c  = bus.start & bus.rd_en & ~bus.byte_mode & (count_q >= CNT_W'(1));

  // Next-state logic for pointers, count and output registers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = 8'h00;
    en_d     = 1'b0;
`ifdef DATA_SPLIT_UNDERRUN_EN
    un_d     = 1'b0;
`endif

    if (pop_byte_c) begin
      data_d   = {mem_q[rd_ptr_q], mem_q[rd_next_c]};
      en_d     = 1'b1;
      rd_ptr_d = ptr_add(rd_ptr_q, 2);
      count_d  = count_d - CNT_W'(2);
    end else if (pop_nib_c) begin
      data_d   = {4'h0, mem_q[rd_ptr_q]};
      en_d     = 1'b1;
      rd_ptr_d = rd_next_c;
      count_d  = count_d - CNT_W'(1);
    end else begin
`ifdef DATA_SPLIT_UNDERRUN_EN
      un_d = bus.start & bus.rd_en;
`endif
    end

    if (push_c) begin
      wr_ptr_d = ptr_add(wr_ptr_q, 2);
      count_d  = count_d + CNT_W'(2);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= 8'h00;
      en_q     <= 1'b0;
`ifdef DATA_SPLIT_UNDERRUN_EN
      un_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      en_q     <= en_d;
`ifdef DATA_SPLIT_UNDERRUN_EN
      un_q     <= un_d;
`endif
    end
  end

  // Nibble storage; high nibble lands first so it is read out first.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q]  <= bus.data_in[7:4];
      mem_q[wr_next_c] <= bus.data_in[3:0];
    end
  end

  assign bus.data_o  = data_q;
  assign bus.data_en = en_q;
`ifdef DATA_SPLIT_UNDERRUN_EN
  assign bus.underrun = un_q;
`endif

endmodule

// File: tb/tb_data_split.sv
// tb_data_split: self-checking bench for data_split. A nibble queue models the
// buffer; every cycle the bench predicts ready, data_o, data_en (and underrun
// when DATA_SPLIT_UNDERRUN_EN is defined) and compares against the DUT.
module tb_data_split;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic reset_n;
  data_split_if bus();

  data_split #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0] q[$];
  logic [7:0] exp_do;
  logic       exp_en;
  logic       exp_un;
  logic       exp_rdy;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic cyc(input logic rst, input logic st, input logic v,
                     input logic [7:0] d, input logic rd, input logic by);
    logic [3:0] a;
    logic [3:0] b;
    reset_n           = rst;
    bus.start         = st;
    bus.data_in_valid = v;
    bus.data_in       = d;
    bus.rd_en         = rd;
    bus.byte_mode     = by;
    #1;
    exp_rdy = rst & st & (q.size() <= DEPTH - 2);
    chk1("ready", bus.data_in_ready, exp_rdy);
    exp_do = 8'h00;
    exp_en = 1'b0;
    exp_un = 1'b0;
    if (!rst) begin
      q.delete();
    end else begin
      if (st && rd && by && q.size() >= 2) begin
        a = q.pop_front();
        b = q.pop_front();
        exp_do = {a, b};
        exp_en = 1'b1;
      end else if (st && rd && !by && q.size() >= 1) begin
        a = q.pop_front();
        exp_do = {4'h0, a};
        exp_en = 1'b1;
      end else begin
        exp_un = st & rd;
      end
      if (v && exp_rdy) begin
        q.push_back(d[7:4]);
        q.push_back(d[3:0]);
      end
    end
    @(posedge clk);
    #1;
    chk8("data_o", bus.data_o, exp_do);
    chk1("data_en", bus.data_en, exp_en);
`ifdef DATA_SPLIT_UNDERRUN_EN
    chk1("underrun", bus.underrun, exp_un);
`endif
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic by);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, by);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.data_in = 8'h00;
    bus.data_in_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.byte_mode = 1'b0;

    // Reset state
    cyc(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    chk8("rst_data_o", bus.data_o, 8'h00);
    chk1("rst_data_en", bus.data_en, 1'b0);
    chk1("rst_ready", bus.data_in_ready, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // 0x84 drained as two nibbles
    push(8'h84);
    pop(1'b0);
    chk8("n84_hi", bus.data_o, 8'h08);
    chk1("n84_hi_en", bus.data_en, 1'b1);
    pop(1'b0);
    chk8("n84_lo", bus.data_o, 8'h04);
    chk1("n84_lo_en", bus.data_en, 1'b1);
    idle();
    chk1("n84_done_en", bus.data_en, 1'b0);

    // 0x21 as a byte
    push(8'h21);
    pop(1'b1);
    chk8("b21", bus.data_o, 8'h21);
    chk1("b21_en", bus.data_en, 1'b1);
    idle();
    chk1("b21_single", bus.data_en, 1'b0);

    // Mixed widths over 0x69, 0xA5 (second push overlaps first pop)
    push(8'h69);
    cyc(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    chk8("mix_06", bus.data_o, 8'h06);
    pop(1'b1);
    chk8("mix_9a", bus.data_o, 8'h9A);
    pop(1'b0);
    chk8("mix_05", bus.data_o, 8'h05);
    pop(1'b1);
    chk1("mix_under_en", bus.data_en, 1'b0);
`ifdef DATA_SPLIT_UNDERRUN_EN
    chk1("mix_under", bus.underrun, 1'b1);
`endif

    // Full boundary and pointer wrap
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk1("full_ready_low", bus.data_in_ready, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    chk8("full_pop11", bus.data_o, 8'h11);
    chk1("full_ready_back", bus.data_in_ready, 1'b1);
    push(8'h55);
    pop(1'b1);
    chk8("wrap_22", bus.data_o, 8'h22);
    pop(1'b1);
    chk8("wrap_33", bus.data_o, 8'h33);
    pop(1'b1);
    chk8("wrap_44", bus.data_o, 8'h44);
    pop(1'b1);
    chk8("wrap_55", bus.data_o, 8'h55);
    pop(1'b1);
    chk1("wrap_empty_en", bus.data_en, 1'b0);

    // Lone nibble: byte request leaves it in place
    push(8'h37);
    pop(1'b0);
    chk8("lone_03", bus.data_o, 8'h03);
    pop(1'b1);
    chk1("lone_byte_en", bus.data_en, 1'b0);
`ifdef DATA_SPLIT_UNDERRUN_EN
    chk1("lone_under", bus.underrun, 1'b1);
`endif
    pop(1'b0);
    chk8("lone_07", bus.data_o, 8'h07);

    // start low holds contents
    push(8'hBC);
    cyc(1'b1, 1'b0, 1'b1, 8'hDE, 1'b1, 1'b1);
    chk1("hold_en", bus.data_en, 1'b0);
    chk1("hold_ready", bus.data_in_ready, 1'b0);
    pop(1'b1);
    chk8("hold_bc", bus.data_o, 8'hBC);

    // Mid-operation reset discards data
    push(8'h01);
    push(8'h02);
    push(8'h03);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    chk8("mrst_data_o", bus.data_o, 8'h00);
    chk1("mrst_en", bus.data_en, 1'b0);
    pop(1'b0);
    chk1("mrst_empty_en", bus.data_en, 1'b0);
`ifdef DATA_SPLIT_UNDERRUN_EN
    chk1("mrst_under", bus.underrun, 1'b1);
`endif
    cyc(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    chk1("off_ready", bus.data_in_ready, 1'b0);
    pop(1'b0);
    chk1("off_nothing_taken", bus.data_en, 1'b0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 1)),
          8'($urandom),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
